uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Buffered UART transmitter: the counterpart of uart_rx in buff_uart.
- Accepts parallel words through a valid/ready handshake into a small FIFO.
- Serialises each word as an 8N1-style frame: start bit, width data bits LSB first, one stop bit.
- Frame timing is identical to uart_rx, so uart_tx.signal can drive uart_rx.signal directly for loopback.

Parameters:
- width, 8, data bits per frame.
- baud_rate, 9600, bit rate in bits/s.
- clock_freq, 460800, clock frequency in Hz; ticks_per_bit = clock_freq / baud_rate (48 by default).
- fifo_depth, 4, word FIFO entries; power of two, >= 2.

Ports:
- clock  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- data  input  width  word to transmit.
- valid  input  1  data is presented.
- ready  output  1  FIFO can accept a word; ready = !full.
- signal  output  1  serial line, registered, idle high.
- busy  output  1  frame in progress or FIFO non-empty.

Behaviour:
- Reset (async, resetn=0):
  - signal=1, busy=0, ready=1, FIFO empty, FSM IDLE, bit/tick counters 0.
  - Asserting reset mid-frame aborts the frame immediately: signal returns high and queued words are discarded.
- Push: at a rising edge with valid && ready, data is written to the FIFO. valid without ready is ignored and nothing is stored. data is sampled only on push.
- Full: ready is low whenever count == fifo_depth. A push is refused on a full FIFO even if a pop occurs on the same edge; the word can be accepted on the next cycle.
- FSM states and transitions:
  - IDLE: signal=1. At an edge with FIFO non-empty: pop the head into the shift register, signal<=0, tick counter = 0, go to START.
  - START: signal=0 for exactly ticks_per_bit clocks, then go to DATA with bit index 0 and signal<=shift[0].
  - DATA: each bit is held exactly ticks_per_bit clocks, LSB first. After bit width-1, signal<=1 and go to STOP.
  - STOP: signal=1 for ticks_per_bit clocks. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Latency: a word pushed at edge N into an empty FIFO while IDLE produces the signal falling edge at edge N+1.
- Frame length is exactly (width+2)*ticks_per_bit clocks. Back-to-back frames have no gap.
- A push and a pop on the same edge leave count unchanged. FIFO pointers wrap modulo fifo_depth.
- busy = (state != IDLE) || (count != 0). busy drops on the edge that returns the FSM to IDLE with an empty FIFO.
- Arithmetic and elaboration checks:
  - Tick counter width is $clog2(ticks_per_bit); bit index width is $clog2(width).
  - Elaboration fails if ticks_per_bit < 2 or if fifo_depth is not a power of two.

Test Plan:
- Single word: reset, then push 0xA5 once. Expect signal low for 48 clocks, then bits 1,0,1,0,0,1,0,1 at 48 clocks each, then high 48 clocks. busy is high for 480 clocks, then 0.
- Fill/backpressure: hold valid and push 0x01..0x06 on consecutive cycles. Expect 5 words accepted (the first is popped at edge N+1), ready low at the sixth. The sixth is accepted the cycle after the first frame's STOP pops the next word. Six frames go out back-to-back with no idle clocks, in order.
- Loopback: uart_tx.signal drives a uart_rx with the same parameters. Push all 256 values 0..255 with random 0..2-frame gaps. Expect each received word to equal the sent one, with exactly one rx ready pulse per frame.
- Reset mid-frame: push 0x3C and 0x7E, then assert resetn low at clock 200 of the first frame. Expect signal=1 immediately, busy=0, ready=1. After release, signal stays high with no further frames.
- Ignored input: toggle data with valid=0 for 1000 clocks. Expect signal constantly 1, busy=0, FIFO empty.
- Stop-to-start: push a second word exactly on the last STOP clock of the first frame. Expect the START of the second frame immediately after STOP, with no gap and no lost word.

Source files
------------

// File: rtl/uart_tx.sv
// Buffered UART transmitter: valid/ready word FIFO feeding an 8N1-style serialiser.
// Frame = start bit, width data bits LSB first, one stop bit; each bit lasts clock_freq/baud_rate clocks.
module uart_tx #(
  parameter int width      = 8,
  parameter int baud_rate  = 9600,
  parameter int clock_freq = 460800,
  parameter int fifo_depth = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [width-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             signal,
  output logic             busy
);

  localparam int TPB = clock_freq / baud_rate;
  localparam int TW  = (TPB > 1) ? $clog2(TPB) : 1;
  localparam int BW  = (width > 1) ? $clog2(width) : 1;
  localparam int PW  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW  = PW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TPB - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(fifo_depth);

  if (TPB < 2) begin : g_tpb_check
    $error("uart_tx: clock_freq/baud_rate must be at least 2");
  end
  if ((fifo_depth < 2) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_depth_check
    $error("uart_tx: fifo_depth must be a power of two and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [width-1:0] r_mem [fifo_depth];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state;
  logic [TW-1:0]    r_tick;
  logic [BW-1:0]    r_bit;
  logic [width-1:0] r_shift;
  logic             r_signal;

  state_t           w_state_nxt;
  logic [TW-1:0]    w_tick_nxt;
  logic [BW-1:0]    w_bit_nxt;
  logic [width-1:0] w_shift_nxt;
  logic             w_signal_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_nempty;
  logic             w_tick_end;

  assign ready    = (r_count != FULL_CNT);
  assign w_push   = valid && ready;
  assign w_nempty = (r_count != '0);
  assign busy     = (r_state != S_IDLE) || w_nempty;
  assign signal   = r_signal;

  // Storage needs no reset: only entries written since reset are ever read.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_signal <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_signal <= w_signal_nxt;
    end
  end

  assign w_tick_end = (r_tick == TICK_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_signal_nxt = r_signal;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_signal_nxt = 1'b1;
        if (w_nempty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = r_mem[r_rd_ptr];
          w_signal_nxt = 1'b0;
          w_tick_nxt   = '0;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (w_tick_end) begin
          w_tick_nxt   = '0;
          w_bit_nxt    = '0;
          w_signal_nxt = r_shift[0];
          w_shift_nxt  = r_shift >> 1;
          w_state_nxt  = S_DATA;
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      S_DATA: begin
        if (w_tick_end) begin
          w_tick_nxt = '0;
          if (r_bit == BIT_LAST) begin
            w_signal_nxt = 1'b1;
            w_state_nxt  = S_STOP;
          end else begin
            w_bit_nxt    = r_bit + BW'(1);
            w_signal_nxt = r_shift[0];
            w_shift_nxt  = r_shift >> 1;
          end
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      S_STOP: begin
        if (w_tick_end) begin
          w_tick_nxt = '0;
          // A queued word goes straight into the next start bit, so frames abut.
          if (w_nempty) begin
            w_pop        = 1'b1;
            w_shift_nxt  = r_mem[r_rd_ptr];
            w_signal_nxt = 1'b0;
            w_state_nxt  = S_START;
          end else begin
            w_signal_nxt = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end
      default: begin
        w_signal_nxt = 1'b1;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: accepted words go into a scoreboard queue; a serial-line
// monitor decodes each frame, checks its shape bit by bit and pops/compares the word.
module tb_uart_tx;
  localparam int TPB   = 48;
  localparam int FRAME = 10 * TPB;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] data   = 8'h00;
  logic       valid  = 1'b0;
  logic       ready;
  logic       signal;
  logic       busy;

  uart_tx dut (
    .clock  (clock),
    .resetn (resetn),
    .data   (data),
    .valid  (valid),
    .ready  (ready),
    .signal (signal),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];
  int starts[$];
  int frames_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Serial-line monitor: samples on the falling clock edge.
  initial begin : monitor
    logic [7:0] exp_w;
    logic [7:0] got;
    int errs;
    int slot;
    bit have;
    bit aborted;
    logic eb;
    forever begin
      @(negedge clock);
      if (resetn && signal === 1'b0) begin
        starts.push_back(cyc);
        have = (sb.size() > 0);
        check("frame_expected", int'(have), 1);
        exp_w   = have ? sb.pop_front() : 8'h00;
        errs    = 0;
        got     = 8'h00;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clock);
          if (!resetn) begin
            aborted = 1'b1;
            break;
          end
          slot = k / TPB;
          if (slot == 0)      eb = 1'b0;
          else if (slot == 9) eb = 1'b1;
          else                eb = exp_w[slot-1];
          if (signal !== eb) errs++;
          if ((k % TPB) == TPB / 2 && slot >= 1 && slot <= 8) got[slot-1] = signal;
        end
        if (!aborted) begin
          check("frame_shape", errs, 0);
          check("frame_data", int'(got), int'(exp_w));
          frames_seen++;
        end
      end
    end
  end

  // Called just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic push(input logic [7:0] d, output int refused);
    refused = 0;
    data  = d;
    valid = 1'b1;
    forever begin
      @(negedge clock);
      if (ready === 1'b1) begin
        sb.push_back(d);
        @(posedge clock);
        #1;
        valid = 1'b0;
        return;
      end
      refused++;
      if (refused > 3000) begin
        total++;
        bad++;
        $display("FAIL push_timeout: word %0d never accepted", d);
        @(posedge clock);
        #1;
        valid = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%b expected 0", busy);
    end
    repeat (5) @(posedge clock);
    #1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int ref_cnt;
    int n;
    int f0;
    int lows, busys, nreadys;
    int gap;
    logic [7:0] vals[32];

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_signal", int'(signal), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(ready), 1);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Single word 0xA5: falling edge one clock after the push, busy for the 480 frame clocks.
    push(8'hA5, ref_cnt);
    check("busy_after_push", int'(busy), 1);
    check("latency_pre", int'(signal), 1);
    @(posedge clock);
    #1;
    check("latency_fall", int'(signal), 0);
    n = 0;
    @(negedge clock);
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clock);
    end
    check("busy_len", n, FRAME);
    repeat (2) @(posedge clock);
    #1;
    check("single_frames", frames_seen, 1);

    // Fill and backpressure: 0x01..0x06 on consecutive cycles.
    starts.delete();
    f0 = frames_seen;
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      push(8'(i), ref_cnt);
      n += ref_cnt;
    end
    check("fill_first_five_refused", n, 0);
    // Sixth waits while the FIFO holds four words: edges E2+3..E2+479 refuse.
    push(8'h06, ref_cnt);
    check("fill_sixth_refused", ref_cnt, 477);
    wait_idle();
    check("fill_frames", frames_seen - f0, 6);
    if (starts.size() == 6) begin
      for (int k = 1; k < 6; k++) check("fill_b2b_gap", starts[k] - starts[k-1], FRAME);
    end else begin
      check("fill_starts", starts.size(), 6);
    end

    // Second word pushed on the last STOP clock of the first frame.
    starts.delete();
    push(8'hC3, ref_cnt);
    repeat (479) @(posedge clock);
    #1;
    push(8'h3A, ref_cnt);
    wait_idle();
    check("s2s_starts", starts.size(), 2);
    if (starts.size() == 2) check("s2s_gap", starts[1] - starts[0], FRAME);

    // Reset at clock 200 of the first frame.
    starts.delete();
    push(8'h3C, ref_cnt);
    push(8'h7E, ref_cnt);
    repeat (199) @(posedge clock);
    #1;
    resetn = 1'b0;
    sb.delete();
    #1;
    check("midrst_signal", int'(signal), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(ready), 1);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    starts.delete();
    lows = 0;
    busys = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (signal !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    check("postrst_low", lows, 0);
    check("postrst_busy", busys, 0);
    check("postrst_frames", starts.size(), 0);
    @(posedge clock);
    #1;

    // Toggling data with valid low must do nothing.
    lows = 0;
    busys = 0;
    nreadys = 0;
    for (int i = 0; i < 1000; i++) begin
      data = 8'($urandom);
      @(negedge clock);
      if (signal !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
      if (ready !== 1'b1) nreadys++;
      @(posedge clock);
      #1;
    end
    check("ign_signal", lows, 0);
    check("ign_busy", busys, 0);
    check("ign_ready", nreadys, 0);
    check("ign_frames", starts.size(), 0);

    // Word stream with random 0..2-frame gaps.
    for (int i = 0; i < 32; i++) vals[i] = 8'((i * 37 + 11) & 8'hFF);
    vals[0] = 8'h00;
    vals[1] = 8'hFF;
    vals[2] = 8'h55;
    vals[3] = 8'hAA;
    f0 = frames_seen;
    for (int i = 0; i < 32; i++) begin
      push(vals[i], ref_cnt);
      gap = $urandom_range(0, 2);
      repeat (gap * FRAME) @(posedge clock);
      #1;
    end
    wait_idle();
    check("stream_frames", frames_seen - f0, 32);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
